// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the single-clock FIFO family: pointer width and
// threshold legality, reused by later FIFO variants.
package sync_fifo_pkg;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  function automatic int ptr_w(input int addrsize);
    return addrsize + 1;
  endfunction

  function automatic bit thresh_ok(input int depth, input int afull, input int aempty);
    return (afull >= 1) && (afull <= depth) && (aempty >= 0) && (aempty <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Write/read handshake and status bundle of sync_fifo.
interface sync_fifo_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
);
  logic                winc;
  logic [DATASIZE-1:0] wdata;
  logic                wfull;
  logic                walmost_full;
  logic                rinc;
  logic [DATASIZE-1:0] rdata;
  logic                rvalid;
  logic                rempty;
  logic                ralmost_empty;
  logic [ADDRSIZE:0]   count;
  logic                overflow;
  logic                underflow;

  modport master (
    output winc, wdata, rinc,
    input  wfull, walmost_full, rdata, rvalid, rempty, ralmost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc,
    output wfull, walmost_full, rdata, rvalid, rempty, ralmost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_fifomem_reg.sv
// FIFO storage: synchronous write, registered read. Only the read register
// is reset so the array can map onto block RAM.
module fifomem_reg #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                re,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);
  localparam int DEPTH = 1 << ADDRSIZE;

  logic [DATASIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: binary pointers, occupancy/flag decode, read-valid
// strobe and sticky error flags around a registered-read RAM.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATASIZE      = 8,
  parameter int ADDRSIZE      = 4,
  parameter int AFULL_THRESH  = (1 << ADDRSIZE) - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input logic        clk,
  input logic        rst,
  sync_fifo_if.slave f
);
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam int PW    = ptr_w(ADDRSIZE);

  localparam logic [PW-1:0] CNT_FULL = PW'(DEPTH);
  localparam logic [PW-1:0] CNT_AF   = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] CNT_AE   = PW'(AEMPTY_THRESH);

  generate
    if (!thresh_ok(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_thresh
      $error("sync_fifo: AFULL_THRESH/AEMPTY_THRESH out of range");
    end
  endgenerate

  logic [PW-1:0] wptr, rptr, cnt;
  logic          full, empty, we, re;
  logic          rvalid_q, ovf_q, unf_q;

  // Modulo subtraction of the wrap-extended pointers gives 0..DEPTH directly.
  assign cnt   = wptr - rptr;
  assign full  = (cnt == CNT_FULL);
  assign empty = (cnt == '0);
  assign we    = f.winc & ~full;
  assign re    = f.rinc & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (we) wptr <= wptr + 1'b1;
      if (re) rptr <= rptr + 1'b1;
      rvalid_q <= re;
      ovf_q    <= ovf_q | (f.winc & full);
      unf_q    <= unf_q | (f.rinc & empty);
    end
  end

  fifomem_reg #(
    .DATASIZE(DATASIZE),
    .ADDRSIZE(ADDRSIZE)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wptr[ADDRSIZE-1:0]),
    .wdata (f.wdata),
    .re    (re),
    .raddr (rptr[ADDRSIZE-1:0]),
    .rdata (f.rdata)
  );

  assign f.count         = cnt;
  assign f.wfull         = full;
  assign f.rempty        = empty;
  assign f.walmost_full  = (cnt >= CNT_AF);
  assign f.ralmost_empty = (cnt <= CNT_AE);
  assign f.rvalid        = rvalid_q;
  assign f.overflow      = ovf_q;
  assign f.underflow     = unf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed plus random checks of sync_fifo (DEPTH=4) against a queue model.
module tb_sync_fifo;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_if #(.DATASIZE(DW), .ADDRSIZE(AW)) bus ();

  sync_fifo #(
    .DATASIZE(DW), .ADDRSIZE(AW), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .f   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rdata = '0;
  bit m_rvalid = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count",         32'(bus.count),         32'(n));
    chk("rempty",        32'(bus.rempty),        32'(n == 0));
    chk("wfull",         32'(bus.wfull),         32'(n == DEPTH));
    chk("walmost_full",  32'(bus.walmost_full),  32'(n >= AF));
    chk("ralmost_empty", 32'(bus.ralmost_empty), 32'(n <= AE));
    chk("rvalid",        32'(bus.rvalid),        32'(m_rvalid));
    chk("rdata",         32'(bus.rdata),         32'(m_rdata));
    chk("overflow",      32'(bus.overflow),      32'(m_ovf));
    chk("underflow",     32'(bus.underflow),     32'(m_unf));
  endtask

  // One clock: drive, let the edge happen, advance the model, check.
  task automatic step(input bit w, input bit r, input logic [DW-1:0] d);
    bit full, empty;
    bus.winc  = w;
    bus.rinc  = r;
    bus.wdata = d;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_rdata = '0; m_rvalid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      m_rvalid = r && !empty;
      if (r && !empty) m_rdata = q.pop_front();
      if (w && !full)  q.push_back(d);
      if (w && full)   m_ovf = 1'b1;
      if (r && empty)  m_unf = 1'b1;
    end
    #1;
    check_all();
    @(negedge clk);
  endtask

  initial begin
    bus.winc = 1'b0; bus.rinc = 1'b0; bus.wdata = '0;

    // reset with both requests high
    rst = 1'b1;
    step(1, 1, 8'h11);
    step(1, 1, 8'h12);
    rst = 1'b0;

    // fill, then overflow
    step(1, 0, 8'hA0);
    step(1, 0, 8'hA1);
    step(1, 0, 8'hA2);
    step(1, 0, 8'hA3);
    step(1, 0, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 8'h00);
      chk("drain_word", 32'(bus.rdata), 32'(8'hA0 + i));
    end
    step(0, 0, 8'h00);

    // underflow, sticky
    step(0, 1, 8'h00);
    step(0, 0, 8'h00);
    step(1, 0, 8'h33);
    step(0, 1, 8'h00);

    // simultaneous at boundaries, from a clean state
    rst = 1'b1;
    step(0, 0, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 0, 8'hB0 + 8'(i));
    step(1, 1, 8'hBF);
    chk("full_rw_oldest", 32'(bus.rdata), 32'(8'hB0));
    for (int i = 0; i < 3; i++) step(0, 1, 8'h00);
    step(1, 1, 8'hC0);
    chk("empty_rw_count", 32'(bus.count), 32'(1));

    // wrap-around streaming at occupancy 2
    step(1, 0, 8'hC1);
    for (int i = 0; i < 20; i++) step(1, 1, 8'hD0 + 8'(i));

    // reset mid-operation
    step(1, 0, 8'hE0);
    rst = 1'b1;
    step(1, 1, 8'hE1);
    rst = 1'b0;
    step(1, 0, 8'h55);
    step(0, 1, 8'h00);
    chk("post_reset_word", 32'(bus.rdata), 32'(8'h55));

    // random traffic
    for (int i = 0; i < 400; i++)
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 8'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO: the synchronous successor to the dual-port FIFO memory used in our asynchronous FIFO. It wraps a registered-read RAM in pointer, occupancy and flag logic, and adds programmable almost-full/almost-empty thresholds, a live occupancy count, a read-data-valid strobe, and sticky overflow/underflow error flags. It is intended for same-clock-domain buffering between pipeline stages, where gray-code pointer synchronisation is unnecessary.

## Interface
- DATASIZE, 8, data word width in bits
- ADDRSIZE, 4, address bits; DEPTH = 2^ADDRSIZE entries
- AFULL_THRESH, DEPTH-2, walmost_full asserts when count >= this value (legal range 1..DEPTH)
- AEMPTY_THRESH, 1, ralmost_empty asserts when count <= this value (legal range 0..DEPTH-1)
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- winc  in  1  write request
- wdata  in  DATASIZE  write data
- wfull  out  1  FIFO holds DEPTH entries
- walmost_full  out  1  count >= AFULL_THRESH
- rinc  in  1  read request
- rdata  out  DATASIZE  registered read data
- rvalid  out  1  rdata carries a newly popped word this cycle
- rempty  out  1  FIFO holds 0 entries
- ralmost_empty  out  1  count <= AEMPTY_THRESH
- count  out  ADDRSIZE+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

## Operation
- Pointers: wptr and rptr are ADDRSIZE+1-bit binary counters that wrap modulo 2^(ADDRSIZE+1). The RAM address is the low ADDRSIZE bits.
- Occupancy: count = wptr - rptr, computed modulo 2^(ADDRSIZE+1). rempty = (count == 0). wfull = (count == DEPTH).
- Accepted write: we = winc & ~wfull. The word is written to mem[wptr[ADDRSIZE-1:0]] and wptr increments.
- Accepted read: re = rinc & ~rempty. mem[rptr[ADDRSIZE-1:0]] is loaded into the rdata register, rvalid is set for one cycle, and rptr increments.
- Both accepted in the same cycle: count is unchanged and both pointers advance.
- While full: a simultaneous winc and rinc accepts the read and rejects the write, because wfull is evaluated on the pre-edge state. After the edge, count = DEPTH-1.
- While empty: a simultaneous winc and rinc accepts the write and rejects the read. rvalid stays 0. After the edge, count = 1.
- RAM read/write collision cannot occur: a read is never accepted from an empty FIFO, so the read address never equals a same-cycle write address holding unwritten data. No bypass path is required.
- overflow sets on winc & wfull. underflow sets on rinc & rempty. Both stay set until rst.
- rdata holds its value when no read is accepted.
- Reset values: wptr = 0, rptr = 0, count = 0, rempty = 1, wfull = 0, walmost_full = 0, ralmost_empty = 1, rdata = 0, rvalid = 0, overflow = 0, underflow = 0. RAM contents are not reset.
- Reset mid-operation: all buffered data is discarded. winc and rinc are ignored in the reset cycle. The flags read as empty from the first cycle after reset.

## Timing
- All outputs come from registers, or are decoded purely from registered count/pointers. There is no combinational path from winc or rinc to any output.
- Write-to-read latency: a word written at edge N makes rempty fall after edge N. A read requested in cycle N+1 presents rdata, with rvalid = 1, after edge N+2.
- Read latency: 1 cycle from an accepted rinc to rdata/rvalid.
- Status flags and count update after the same edge that accepts the operation.
- Full throughput: one write and one read per cycle, sustained, at any occupancy.

## Structure
- sync_fifo_pkg holds the shared pointer width function (ADDRSIZE+1) and a parameter-legality check (AFULL_THRESH and AEMPTY_THRESH ranges), reused by future FIFO variants.
- A single sub-module, fifomem_reg, implements the RAM: synchronous write when we is high, and a registered read into rdata when re is high, with synchronous reset of the read register only. This lets it map to block RAM.
- sync_fifo contains the pointers, count, flag decode, rvalid and the sticky error flags.

## Test plan
All directed tests use DATASIZE=8, ADDRSIZE=2 (DEPTH=4), AFULL_THRESH=3, AEMPTY_THRESH=1.
- Reset: assert rst for 2 cycles with winc=rinc=1.
  - Required: count=0, rempty=1, ralmost_empty=1, wfull=0, rvalid=0, rdata=0, overflow=0, underflow=0.
- Fill, then overflow:
  - Write 0xA0, 0xA1, 0xA2. Required: count=3, walmost_full=1, wfull=0.
  - Write 0xA3. Required: wfull=1.
  - Write 0xFF while full. Required: count stays 4, overflow=1.
  - Drain. Required: rdata sequence 0xA0..0xA3, each with rvalid=1 one cycle after its rinc. 0xFF never appears.
- Underflow: rinc while empty.
  - Required: rvalid=0, rdata unchanged, underflow=1 and held until rst.
- Simultaneous at boundaries:
  - With count=4, apply winc+rinc. Required: read of the oldest word, count=3, no overflow.
  - With count=0, apply winc+rinc. Required: count=1, rvalid=0, no underflow.
- Wrap-around streaming: 20 consecutive cycles of winc+rinc after pre-loading 2 words.
  - Required: count stays 2, and output order equals input order across multiple pointer wraps.
- Reset mid-operation: with count=3, assert rst for 1 cycle.
  - Required: the reset state of the Reset test. Next write 0x55 then read returns 0x55.
